// File: rtl/upuart_tx_fifo.sv
// upuart_tx_fifo: 8-bit UART transmitter with a small transmit FIFO.
//
// Frames are a start bit, 8 data bits LSB first, an optional even-parity
// bit, then STOP_BITS stop bits. Each bit lasts BAUD_DIV clocks. A new frame
// starts only from IDLE when the FIFO holds a byte and cts is high.
//
// Optional feature macro: UPUART_TX_PARITY_EN (adds an even-parity bit).
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous reset, active-high
//   data_in  byte to enqueue
//   data_wr  enqueue strobe
//   full     FIFO holds FIFO_DEPTH entries
//   empty    FIFO holds no entries
//   ovf      sticky: write attempted while full (cleared by rst only)
//   cts      peer ready, sampled only in IDLE
//   busy     frame in progress
//   txd      serial output, idle high
module upuart_tx_fifo #(
  parameter int unsigned BAUD_DIV   = 217,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_wr,
  output logic       full,
  output logic       empty,
  output logic       ovf,
  input  logic       cts,
  output logic       busy,
  output logic       txd
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [15:0] BitLoad = 16'(BAUD_DIV - 1);
  localparam logic [CntW-1:0] DepthVal = CntW'(FIFO_DEPTH);
  localparam logic [2:0] LastStop = 3'(STOP_BITS - 1);

`ifdef UPUART_TX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  logic [7:0]      mem [FIFO_DEPTH];
  logic [PtrW-1:0] head_q, tail_q;
  logic [CntW-1:0] count_q, count_d;
  logic            ovf_q;
  state_e          state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            push, pop, bit_done;
`ifdef UPUART_TX_PARITY_EN
  logic            parity_q;
`endif

  // Flags decode the registered count only; no path from data_wr.
  assign full     = (count_q == DepthVal);
  assign empty    = (count_q == '0);
  assign ovf      = ovf_q;
  assign busy     = (state_q != StIdle);
  assign push     = data_wr && !full;
  assign pop      = (state_q == StIdle) && !empty && cts;
  assign bit_done = (cnt_q == 16'd0);

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    case (state_q)
      StIdle: begin
        if (pop) begin
          state_d = StStart;
          cnt_d   = BitLoad;
          shift_d = mem[head_q];
        end
      end
      StStart: begin
        if (bit_done) begin
          state_d   = StData;
          cnt_d     = BitLoad;
          bit_idx_d = 3'd0;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StData: begin
        if (bit_done) begin
          cnt_d   = BitLoad;
          shift_d = shift_q >> 1;
          if (bit_idx_q == 3'd7) begin
`ifdef UPUART_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
            bit_idx_d = 3'd0;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
`ifdef UPUART_TX_PARITY_EN
      StParity: begin
        if (bit_done) begin
          state_d   = StStop;
          cnt_d     = BitLoad;
          bit_idx_d = 3'd0;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
`endif
      StStop: begin
        // bit_idx counts stop bits so the 16-bit timer never needs 2*BAUD_DIV.
        if (bit_done) begin
          if (bit_idx_q == LastStop) begin
            state_d = StIdle;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            cnt_d     = BitLoad;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    txd = 1'b1;
    case (state_q)
      StStart:  txd = 1'b0;
      StData:   txd = shift_q[0];
`ifdef UPUART_TX_PARITY_EN
      StParity: txd = parity_q;
`endif
      default:  txd = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[tail_q] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      state_q   <= StIdle;
      cnt_q     <= 16'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
    end else begin
      if (push) tail_q <= tail_q + PtrW'(1);
      if (pop) head_q <= head_q + PtrW'(1);
      if (data_wr && full) ovf_q <= 1'b1;
      count_q   <= count_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

`ifdef UPUART_TX_PARITY_EN
  // Parity is captured at pop because the shift register is consumed by DATA.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else if (pop) begin
      parity_q <= ^mem[head_q];
    end
  end
`endif

endmodule

// File: tb/tb_upuart_tx_fifo.sv
// Testbench for upuart_tx_fifo: constant vector table, directed frame
// sequences and randomized traffic against a queue-based waveform model.
module tb_upuart_tx_fifo;

  localparam int BD    = 4;
  localparam int DEPTH = 4;
  localparam int SB    = 1;
`ifdef UPUART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME = (1 + 8 + PAR + SB) * BD;

  logic clk = 1'b0;
  logic rst, data_wr, cts, full, empty, ovf, busy, txd;
  logic [7:0] data_in;

  always #5 clk = ~clk;

  upuart_tx_fifo #(
    .BAUD_DIV  (BD),
    .FIFO_DEPTH(DEPTH),
    .STOP_BITS (SB)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .data_in(data_in),
    .data_wr(data_wr),
    .full   (full),
    .empty  (empty),
    .ovf    (ovf),
    .cts    (cts),
    .busy   (busy),
    .txd    (txd)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, the line as a queue of per-cycle txd values.
  logic [7:0] m_q[$];
  logic       m_wave[$];
  logic       m_ovf = 1'b0;

  task automatic model_step();
    logic [7:0] b;
    logic start, can_push;
    if (rst) begin
      m_q.delete();
      m_wave.delete();
      m_ovf = 1'b0;
      return;
    end
    start    = (m_wave.size() == 0) && (m_q.size() > 0) && cts;
    can_push = (m_q.size() < DEPTH);
    if (data_wr && !can_push) m_ovf = 1'b1;
    if (m_wave.size() > 0) void'(m_wave.pop_front());
    if (start) begin
      b = m_q.pop_front();
      repeat (BD) m_wave.push_back(1'b0);
      for (int i = 0; i < 8; i++) repeat (BD) m_wave.push_back(b[i]);
      if (PAR != 0) repeat (BD) m_wave.push_back(^b);
      repeat (SB * BD) m_wave.push_back(1'b1);
    end
    if (data_wr && can_push) m_q.push_back(data_in);
  endtask

  function automatic logic [4:0] model_out();
    logic t;
    t = (m_wave.size() > 0) ? m_wave[0] : 1'b1;
    return {t, m_wave.size() > 0, m_q.size() == 0, m_q.size() == DEPTH, m_ovf};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("model", {txd, busy, empty, full, ovf}, model_out());
  endtask

  task automatic do_reset();
    rst = 1'b1; data_wr = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // Waits for a start bit, then samples one frame at bit centres.
  task automatic recv(output logic [7:0] b, output logic p, output int len, output int gap,
                      input int drop_off);
    gap = 0; b = 8'h00; p = 1'b0; len = 0;
    while (txd !== 1'b0 && gap < 4 * FRAME) begin
      tick();
      gap++;
    end
    check("frame_start", txd, 1'b0);
    if (txd !== 1'b0) return;
    for (int off = 0; busy === 1'b1 && off < 2 * FRAME; off++) begin
      for (int i = 0; i < 8; i++) if (off == BD * (1 + i) + BD / 2) b[i] = txd;
      if (off == 9 * BD + BD / 2) p = txd;
      if (off == drop_off) cts = 1'b0;
      len++;
      tick();
    end
  endtask

  typedef struct {
    logic       rst;
    logic       wr;
    logic [7:0] d;
    logic       cts;
    logic [4:0] exp; // {txd, busy, empty, full, ovf}
  } vec_t;

  vec_t vt[9];
  logic [7:0] rb;
  logic rp;
  int rlen, rgap, bad;

  initial begin
    vt[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 5'b10100};
    vt[1] = '{1'b0, 1'b1, 8'h01, 1'b0, 5'b10000};
    vt[2] = '{1'b0, 1'b1, 8'h02, 1'b0, 5'b10000};
    vt[3] = '{1'b0, 1'b1, 8'h03, 1'b0, 5'b10000};
    vt[4] = '{1'b0, 1'b1, 8'h04, 1'b0, 5'b10010};
    vt[5] = '{1'b0, 1'b1, 8'h05, 1'b0, 5'b10011};
    vt[6] = '{1'b0, 1'b0, 8'h00, 1'b1, 5'b01001};
    vt[7] = '{1'b0, 1'b1, 8'h06, 1'b1, 5'b01011};
    vt[8] = '{1'b1, 1'b0, 8'h00, 1'b0, 5'b10100};

    rst = 1'b1; data_wr = 1'b0; data_in = 8'h00; cts = 1'b0;
    for (int i = 0; i < 9; i++) begin
      rst = vt[i].rst; data_wr = vt[i].wr; data_in = vt[i].d; cts = vt[i].cts;
      tick();
      check($sformatf("vec%0d", i), {txd, busy, empty, full, ovf}, vt[i].exp);
    end
    rst = 1'b0; data_wr = 1'b0;

    // Single byte 0x55: first-write latency, bit order, frame length.
    cts = 1'b1; data_in = 8'h55; data_wr = 1'b1;
    tick();
    data_wr = 1'b0;
    check("single_empty", empty, 1'b0);
    recv(rb, rp, rlen, rgap, -1);
    check("single_latency", rgap, 1);
    check("single_byte", rb, 8'h55);
    check("single_len", rlen, FRAME);

`ifdef UPUART_TX_PARITY_EN
    data_in = 8'h07; data_wr = 1'b1; tick(); data_wr = 1'b0;
    recv(rb, rp, rlen, rgap, -1);
    check("par07_byte", rb, 8'h07);
    check("par07_bit", rp, 1'b1);
    check("par07_len", rlen, 11 * BD);
    data_in = 8'h03; data_wr = 1'b1; tick(); data_wr = 1'b0;
    recv(rb, rp, rlen, rgap, -1);
    check("par03_bit", rp, 1'b0);
`endif

    // Burst of four, sent back-to-back with one idle cycle between frames.
    do_reset();
    cts = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      data_in = 8'(i); data_wr = 1'b1; tick();
    end
    data_wr = 1'b0;
    check("burst_full", full, 1'b1);
    cts = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      recv(rb, rp, rlen, rgap, -1);
      check($sformatf("burst_byte%0d", i), rb, 8'(i));
      if (i > 1) check($sformatf("burst_gap%0d", i), rgap, 1);
    end
    check("burst_empty", empty, 1'b1);

    // Overflow: fifth byte dropped, ovf sticky, exactly four frames.
    do_reset();
    cts = 1'b0;
    for (int i = 0; i < 5; i++) begin
      data_in = 8'h11 + 8'(i); data_wr = 1'b1; tick();
    end
    data_wr = 1'b0;
    check("ovf_set", ovf, 1'b1);
    cts = 1'b1;
    for (int i = 0; i < 4; i++) begin
      recv(rb, rp, rlen, rgap, -1);
      check($sformatf("ovf_byte%0d", i), rb, 8'h11 + 8'(i));
    end
    bad = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick();
      if (busy !== 1'b0 || txd !== 1'b1) bad++;
    end
    check("ovf_no_fifth", bad, 0);
    check("ovf_sticky", ovf, 1'b1);

    // Flow control: cts dropped during the first frame's data bits.
    do_reset();
    cts = 1'b0;
    data_in = 8'hA5; data_wr = 1'b1; tick();
    data_in = 8'h3C; tick();
    data_wr = 1'b0; cts = 1'b1;
    recv(rb, rp, rlen, rgap, 3 * BD);
    check("flow_first", rb, 8'hA5);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if ({txd, busy, empty} !== 3'b100) bad++;
    end
    check("flow_held", bad, 0);
    cts = 1'b1;
    recv(rb, rp, rlen, rgap, -1);
    check("flow_resume_latency", rgap, 1);
    check("flow_second", rb, 8'h3C);

    // Reset during data bit 3 with two bytes still queued.
    do_reset();
    cts = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_in = 8'h00; data_wr = 1'b1; tick();
    end
    data_wr = 1'b0;
    repeat (4 * BD) tick();
    check("pre_reset_txd", txd, 1'b0);
    rst = 1'b1; tick(); rst = 1'b0;
    check("mid_reset", {txd, busy, empty, full}, 4'b1010);
    bad = 0;
    for (int i = 0; i < 15 * BD; i++) begin
      tick();
      if (busy !== 1'b0) bad++;
    end
    check("mid_reset_quiet", bad, 0);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      rst     = ($urandom_range(399) == 0);
      data_wr = ($urandom_range(2) == 0);
      data_in = 8'($urandom);
      if ($urandom_range(49) == 0) cts = ~cts;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
